// File: rtl/adc_serial_reader_if.sv
// Bundles the ADC pin-level signals and the downstream control/sample handshake.
// The master modport is the reader; slave is the environment driving the ADC pins and control.
interface adc_serial_reader_if #(
    parameter int unsigned DATA_W = 16
);
    logic              ena;
    logic              start;
    logic              adc_nconv;
    logic              adc_busy;
    logic              adc_sclk;
    logic              adc_sdout;
    logic [DATA_W-1:0] data;
    logic              data_valid;
    logic              frame_err;
    logic              timeout_err;
    logic              rdy;

    modport master (
        input  ena, start, adc_busy, adc_sclk, adc_sdout,
        output adc_nconv, data, data_valid, frame_err, timeout_err, rdy
    );

    modport slave (
        output ena, start, adc_busy, adc_sclk, adc_sdout,
        input  adc_nconv, data, data_valid, frame_err, timeout_err, rdy
    );
endinterface

// File: rtl/adc_serial_reader.sv
// Serial ADC front end: issues nCONV, synchronises BUSY/SCLK/SDOUT into clk200 and
// deserialises one MSB-first sample per conversion, flagging short frames and timeouts.
module adc_serial_reader #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned NCONV_MIN   = 4,
    parameter int unsigned TIMEOUT     = 1024
) (
    input logic                 clk200,
    input logic                 nrst,
    adc_serial_reader_if.master bus
);
    localparam int unsigned BIT_W = $clog2(DATA_W + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam int unsigned NCV_W = $clog2(NCONV_MIN + 1);

    localparam logic [BIT_W-1:0] BIT_FULL = BIT_W'(DATA_W);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);
    localparam logic [NCV_W-1:0] NCV_LAST = NCV_W'(NCONV_MIN - 1);

    typedef enum logic [1:0] {StIdle, StConv, StShift, StDone} state_e;

    state_e            state_q, state_d;
    logic              nconv_q, nconv_d;
    logic [NCV_W-1:0]  nconv_cnt_q, nconv_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              frame_err_q, frame_err_d;
    logic              timeout_err_q, timeout_err_d;

    logic [SYNC_STAGES-1:0] busy_sync_q, sclk_sync_q, sdout_sync_q;
    logic                   sclk_s_d_q;
    logic                   busy_s, sclk_s, sdout_s, sclk_rise;

    // Equal chain depths keep sdout_s aligned with sclk_s.
    always_ff @(posedge clk200 or posedge nrst) begin
        if (nrst) begin
            busy_sync_q  <= '0;
            sclk_sync_q  <= '0;
            sdout_sync_q <= '0;
            sclk_s_d_q   <= 1'b0;
        end else begin
            busy_sync_q  <= {busy_sync_q[SYNC_STAGES-2:0], bus.adc_busy};
            sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], bus.adc_sclk};
            sdout_sync_q <= {sdout_sync_q[SYNC_STAGES-2:0], bus.adc_sdout};
            sclk_s_d_q   <= sclk_s;
        end
    end

    assign busy_s    = busy_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign sdout_s   = sdout_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_s_d_q;

    always_ff @(posedge clk200 or posedge nrst) begin
        if (nrst) begin
            state_q       <= StIdle;
            nconv_q       <= 1'b1;
            nconv_cnt_q   <= '0;
            tmo_cnt_q     <= '0;
            bit_cnt_q     <= '0;
            shreg_q       <= '0;
            data_q        <= '0;
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            nconv_q       <= nconv_d;
            nconv_cnt_q   <= nconv_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            data_q        <= data_d;
            frame_err_q   <= frame_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        nconv_d       = nconv_q;
        nconv_cnt_d   = nconv_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shreg_d       = shreg_q;
        data_d        = data_q;
        frame_err_d   = 1'b0;
        timeout_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start && bus.ena) begin
                    state_d     = StConv;
                    nconv_d     = 1'b0;
                    nconv_cnt_d = '0;
                    tmo_cnt_d   = '0;
                end
            end
            StConv: begin
                if (nconv_cnt_q != NCV_LAST) begin
                    nconv_cnt_d = nconv_cnt_q + NCV_W'(1);
                end
                // nCONV is held low until BUSY is seen so the ADC cannot retrigger.
                if (busy_s && nconv_cnt_q >= NCV_LAST) begin
                    state_d   = StShift;
                    nconv_d   = 1'b1;
                    bit_cnt_d = '0;
                    shreg_d   = '0;
                end
            end
            StShift: begin
                if (sclk_rise && bit_cnt_q < BIT_FULL) begin
                    shreg_d   = {shreg_q[DATA_W-2:0], sdout_s};
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
                // Evaluate the post-shift count so a final edge coinciding with BUSY fall counts.
                if (!busy_s) begin
                    if (bit_cnt_d == BIT_FULL) begin
                        state_d = StDone;
                        data_d  = shreg_d;
                    end else begin
                        state_d     = StIdle;
                        frame_err_d = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (state_q == StConv || state_q == StShift) begin
            if (tmo_cnt_q != TMO_MAX) begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
            if (tmo_cnt_q == TMO_LAST) begin
                state_d       = StIdle;
                nconv_d       = 1'b1;
                timeout_err_d = 1'b1;
                frame_err_d   = 1'b0;
                data_d        = data_q;
            end
        end
    end

    assign bus.adc_nconv   = nconv_q;
    assign bus.data        = data_q;
    assign bus.data_valid  = (state_q == StDone);
    assign bus.frame_err   = frame_err_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.rdy         = (state_q == StIdle);
endmodule

// File: tb/tb_adc_serial_reader.sv
// Bench for adc_serial_reader: behavioural ADC model, scoreboard of expected samples,
// and one task per scenario.
`timescale 1ns/100ps
module tb_adc_serial_reader;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned TIMEOUT = 1024;

    logic clk200 = 1'b0;
    logic nrst;

    adc_serial_reader_if #(.DATA_W(DATA_W)) bus ();

    adc_serial_reader #(
        .DATA_W(DATA_W),
        .SYNC_STAGES(2),
        .NCONV_MIN(4),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk200(clk200),
        .nrst(nrst),
        .bus(bus)
    );

    always #2.5 clk200 = ~clk200;

    int n_checks = 0;
    int n_fail = 0;
    int valid_cnt = 0;
    int ferr_cnt = 0;
    int terr_cnt = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] adc_pattern = '0;
    logic [DATA_W-1:0] last_good = '0;
    int adc_nbits = 16;
    bit adc_busy_en = 1'b1;
    bit adc_active = 1'b0;
    int adc_rises = 0;

    // ADC model: BUSY rise presents the MSB, data changes on SCLK falls, BUSY drops after nbits.
    task automatic adc_frame();
        int nb;
        nb = adc_nbits;
        adc_active = 1'b1;
        adc_rises = 0;
        #30.3;
        bus.adc_sdout = adc_pattern[DATA_W-1];
        bus.adc_busy = 1'b1;
        for (int i = DATA_W - 1; i >= int'(DATA_W) - nb; i--) begin
            #(20 + $urandom_range(0, 1));
            bus.adc_sclk = 1'b1;
            adc_rises++;
            #(20 + $urandom_range(0, 1));
            bus.adc_sclk = 1'b0;
            if (i > 0) bus.adc_sdout = adc_pattern[i-1];
        end
        #(20 + $urandom_range(0, 1));
        bus.adc_busy = 1'b0;
        bus.adc_sdout = 1'b0;
        adc_active = 1'b0;
    endtask

    initial begin
        bus.adc_busy = 1'b0;
        bus.adc_sclk = 1'b0;
        bus.adc_sdout = 1'b0;
        forever begin
            @(negedge bus.adc_nconv);
            if (adc_busy_en) adc_frame();
        end
    end

    always @(negedge clk200) begin
        if (bus.data_valid === 1'b1) valid_cnt++;
        if (bus.frame_err === 1'b1) ferr_cnt++;
        if (bus.timeout_err === 1'b1) terr_cnt++;
    end

    task automatic pulse_start();
        @(negedge clk200);
        bus.start = 1'b1;
        @(negedge clk200);
        bus.start = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk200);
        #1;
    endtask

    task automatic wait_valid(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk200);
            if (bus.data_valid === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic wait_adc_idle(output bit idle);
        idle = !adc_active;
        for (int i = 0; i < 3000 && !idle; i++) begin
            @(negedge clk200);
            idle = !adc_active;
        end
    endtask

    task automatic test_reset();
        bus.ena = 1'b0;
        bus.start = 1'b0;
        nrst = 1'b1;
        repeat (2) @(negedge clk200);
        n_checks++;
        if (bus.adc_nconv !== 1'b1) begin
            n_fail++; $display("FAIL reset_nconv: got %b required 1", bus.adc_nconv);
        end
        n_checks++;
        if (bus.data !== 16'h0000) begin
            n_fail++; $display("FAIL reset_data: got %h required 0000", bus.data);
        end
        n_checks++;
        if ({bus.data_valid, bus.frame_err, bus.timeout_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b%b%b required 000",
                     bus.data_valid, bus.frame_err, bus.timeout_err);
        end
        n_checks++;
        if (bus.rdy !== 1'b1) begin
            n_fail++; $display("FAIL reset_rdy: got %b required 1", bus.rdy);
        end
        nrst = 1'b0;
        bus.ena = 1'b1;
        repeat (3) @(negedge clk200);
    endtask

    task automatic test_single();
        int v0, f0, t0, low;
        bit seen, idle;
        logic busy_at_rel;
        logic [DATA_W-1:0] exp;
        v0 = valid_cnt; f0 = ferr_cnt; t0 = terr_cnt;
        adc_pattern = 16'hACCF;
        adc_nbits = 16;
        exp_q.push_back(16'hACCF);
        pulse_start();
        low = 0;
        while (bus.adc_nconv === 1'b0 && low < 300) begin
            @(negedge clk200);
            low++;
        end
        busy_at_rel = bus.adc_busy;
        n_checks++;
        if (low < 4 || low >= 300) begin
            n_fail++; $display("FAIL single_nconv_low: got %0d cycles required 4..299", low);
        end
        n_checks++;
        if (busy_at_rel !== 1'b1) begin
            n_fail++; $display("FAIL single_nconv_release: adc_busy %b required 1", busy_at_rel);
        end
        wait_valid(seen);
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL single_valid: data_valid seen %0d required 1", seen);
        end else begin
            exp = exp_q.pop_front();
            n_checks++;
            if (bus.data !== exp) begin
                n_fail++; $display("FAIL single_data: got %h required %h", bus.data, exp);
            end
            last_good = exp;
            @(negedge clk200);
            n_checks++;
            if (bus.data_valid !== 1'b0) begin
                n_fail++; $display("FAIL single_valid_width: got %b required 0", bus.data_valid);
            end
        end
        wait_adc_idle(idle);
        settle(3);
        n_checks++;
        if (valid_cnt - v0 != 1 || ferr_cnt != f0 || terr_cnt != t0) begin
            n_fail++;
            $display("FAIL single_counts: valid %0d ferr %0d terr %0d required 1 0 0",
                     valid_cnt - v0, ferr_cnt - f0, terr_cnt - t0);
        end
    endtask

    task automatic test_back_to_back();
        int v0, f0, t0;
        bit seen;
        logic [31:0] pat;
        logic [DATA_W-1:0] exp;
        v0 = valid_cnt; f0 = ferr_cnt; t0 = terr_cnt;
        void'($urandom(1));
        @(negedge clk200);
        for (int k = 0; k < 10; k++) begin
            pat = $urandom;
            adc_pattern = pat[DATA_W-1:0];
            exp_q.push_back(pat[DATA_W-1:0]);
            n_checks++;
            if (bus.rdy !== 1'b1) begin
                n_fail++; $display("FAIL b2b_rdy[%0d]: got %b required 1", k, bus.rdy);
            end
            bus.start = 1'b1;
            @(negedge clk200);
            bus.start = 1'b0;
            wait_valid(seen);
            n_checks++;
            if (!seen) begin
                n_fail++; $display("FAIL b2b_valid[%0d]: seen %0d required 1", k, seen);
            end else begin
                exp = exp_q.pop_front();
                n_checks++;
                if (bus.data !== exp) begin
                    n_fail++; $display("FAIL b2b_data[%0d]: got %h required %h", k, bus.data, exp);
                end
                last_good = exp;
            end
            @(negedge clk200);
        end
        settle(3);
        n_checks++;
        if (valid_cnt - v0 != 10 || ferr_cnt != f0 || terr_cnt != t0) begin
            n_fail++;
            $display("FAIL b2b_counts: valid %0d ferr %0d terr %0d required 10 0 0",
                     valid_cnt - v0, ferr_cnt - f0, terr_cnt - t0);
        end
    endtask

    task automatic test_frame_err();
        int v0, f0, t0;
        bit seen, idle;
        v0 = valid_cnt; f0 = ferr_cnt; t0 = terr_cnt;
        adc_pattern = 16'h1234;
        adc_nbits = 9;
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk200);
            if (bus.frame_err === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL ferr_pulse: seen %0d required 1", seen);
        end
        n_checks++;
        if (bus.data !== last_good) begin
            n_fail++; $display("FAIL ferr_data_hold: got %h required %h", bus.data, last_good);
        end
        @(negedge clk200);
        n_checks++;
        if (bus.frame_err !== 1'b0 || bus.rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL ferr_after: frame_err %b rdy %b required 0 1", bus.frame_err, bus.rdy);
        end
        wait_adc_idle(idle);
        adc_nbits = 16;
        settle(3);
        n_checks++;
        if (ferr_cnt - f0 != 1 || valid_cnt != v0 || terr_cnt != t0) begin
            n_fail++;
            $display("FAIL ferr_counts: ferr %0d valid %0d terr %0d required 1 0 0",
                     ferr_cnt - f0, valid_cnt - v0, terr_cnt - t0);
        end
    endtask

    task automatic test_timeout();
        int v0, t0, cnt;
        v0 = valid_cnt; t0 = terr_cnt;
        adc_busy_en = 1'b0;
        pulse_start();
        n_checks++;
        if (bus.adc_nconv !== 1'b0) begin
            n_fail++; $display("FAIL tmo_nconv_low: got %b required 0", bus.adc_nconv);
        end
        cnt = 0;
        while (bus.timeout_err !== 1'b1 && cnt < 2000) begin
            @(negedge clk200);
            cnt++;
        end
        n_checks++;
        if (cnt != int'(TIMEOUT)) begin
            n_fail++; $display("FAIL tmo_latency: got %0d cycles required %0d", cnt, TIMEOUT);
        end
        n_checks++;
        if (bus.adc_nconv !== 1'b1 || bus.rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_state: nconv %b rdy %b required 1 1", bus.adc_nconv, bus.rdy);
        end
        @(negedge clk200);
        n_checks++;
        if (bus.timeout_err !== 1'b0) begin
            n_fail++; $display("FAIL tmo_width: got %b required 0", bus.timeout_err);
        end
        adc_busy_en = 1'b1;
        settle(3);
        n_checks++;
        if (terr_cnt - t0 != 1 || valid_cnt != v0) begin
            n_fail++;
            $display("FAIL tmo_counts: terr %0d valid %0d required 1 0", terr_cnt - t0,
                     valid_cnt - v0);
        end
    endtask

    task automatic test_ignore_start();
        int v0, f0, t0;
        bit seen, idle;
        logic [DATA_W-1:0] exp;
        v0 = valid_cnt; f0 = ferr_cnt; t0 = terr_cnt;
        bus.ena = 1'b0;
        pulse_start();
        repeat (5) @(negedge clk200);
        n_checks++;
        if (bus.rdy !== 1'b1 || bus.adc_nconv !== 1'b1) begin
            n_fail++;
            $display("FAIL ign_ena0: rdy %b nconv %b required 1 1", bus.rdy, bus.adc_nconv);
        end
        bus.ena = 1'b1;
        adc_pattern = 16'h5A3C;
        exp_q.push_back(16'h5A3C);
        pulse_start();
        bus.start = 1'b1;
        @(negedge clk200);
        bus.start = 1'b0;
        idle = 1'b0;
        for (int i = 0; i < 3000 && adc_rises < 3; i++) @(negedge clk200);
        bus.start = 1'b1;
        @(negedge clk200);
        bus.start = 1'b0;
        wait_valid(seen);
        bus.start = 1'b1;
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL ign_valid: seen %0d required 1", seen);
        end else begin
            exp = exp_q.pop_front();
            n_checks++;
            if (bus.data !== exp) begin
                n_fail++; $display("FAIL ign_data: got %h required %h", bus.data, exp);
            end
            last_good = exp;
        end
        @(negedge clk200);
        bus.start = 1'b0;
        wait_adc_idle(idle);
        repeat (400) @(negedge clk200);
        n_checks++;
        if (bus.adc_nconv !== 1'b1 || bus.rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL ign_idle: nconv %b rdy %b required 1 1", bus.adc_nconv, bus.rdy);
        end
        settle(1);
        n_checks++;
        if (valid_cnt - v0 != 1 || ferr_cnt != f0 || terr_cnt != t0) begin
            n_fail++;
            $display("FAIL ign_counts: valid %0d ferr %0d terr %0d required 1 0 0",
                     valid_cnt - v0, ferr_cnt - f0, terr_cnt - t0);
        end
    endtask

    task automatic test_reset_midframe();
        int v0, f0, t0;
        bit seen, idle;
        logic [DATA_W-1:0] exp;
        adc_pattern = 16'hACCF;
        pulse_start();
        for (int i = 0; i < 3000 && adc_rises < 7; i++) @(negedge clk200);
        nrst = 1'b1;
        #1;
        n_checks++;
        if (bus.adc_nconv !== 1'b1 || bus.rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_ctrl: nconv %b rdy %b required 1 1", bus.adc_nconv, bus.rdy);
        end
        n_checks++;
        if (bus.data !== 16'h0000) begin
            n_fail++; $display("FAIL rstmid_data: got %h required 0000", bus.data);
        end
        n_checks++;
        if ({bus.data_valid, bus.frame_err, bus.timeout_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL rstmid_strobes: got %b%b%b required 000",
                     bus.data_valid, bus.frame_err, bus.timeout_err);
        end
        last_good = '0;
        repeat (3) @(negedge clk200);
        nrst = 1'b0;
        settle(1);
        v0 = valid_cnt; f0 = ferr_cnt; t0 = terr_cnt;
        wait_adc_idle(idle);
        n_checks++;
        if (!idle) begin
            n_fail++; $display("FAIL rstmid_adc_idle: idle %0d required 1", idle);
        end
        settle(5);
        n_checks++;
        if (valid_cnt != v0 || ferr_cnt != f0 || terr_cnt != t0) begin
            n_fail++;
            $display("FAIL rstmid_counts: valid %0d ferr %0d terr %0d required 0 0 0",
                     valid_cnt - v0, ferr_cnt - f0, terr_cnt - t0);
        end
        exp_q.push_back(16'hACCF);
        pulse_start();
        wait_valid(seen);
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL rstmid_valid: seen %0d required 1", seen);
        end else begin
            exp = exp_q.pop_front();
            n_checks++;
            if (bus.data !== exp) begin
                n_fail++; $display("FAIL rstmid_data_after: got %h required %h", bus.data, exp);
            end
            last_good = exp;
        end
        wait_adc_idle(idle);
        settle(3);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_frame_err();
        test_timeout();
        test_ignore_start();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/adc_serial_reader.md
Name: adc_serial_reader

Overview:
- FPGA-side controller for a serial-output ADC (nCONV / BUSY / SCLK / SDOUT interface), clocked on clk200.
- Issues conversion requests and brings the ADC-driven signals, which are asynchronous to clk200, into the clk200 domain.
- Deserialises one DATA_W-bit sample per conversion, MSB first, and presents it as a one-cycle valid strobe to downstream processing.
- Detects protocol faults: short frames and missing BUSY.

Parameters:
- DATA_W, 16: sample width in bits; bits per frame.
- SYNC_STAGES, 2: synchroniser depth for adc_busy, adc_sclk and adc_sdout; minimum 2.
- NCONV_MIN, 4: minimum clk200 cycles adc_nconv is held low.
- TIMEOUT, 1024: clk200 cycles allowed from adc_nconv falling to frame end.

Ports:
- clk200  in  1  system clock, 200 MHz.
- nrst  in  1  reset, asynchronous, active-high.
- ena  in  1  enable; when low, start is ignored and any active frame still completes.
- start  in  1  one-cycle conversion request.
- adc_nconv  out  1  conversion request to the ADC, active-low.
- adc_busy  in  1  ADC busy; asynchronous to clk200.
- adc_sclk  in  1  ADC serial clock; asynchronous to clk200.
- adc_sdout  in  1  ADC serial data; asynchronous to clk200.
- data  out  DATA_W  last good sample.
- data_valid  out  1  one-cycle strobe; data is updated in the same cycle.
- frame_err  out  1  one-cycle strobe: BUSY fell before DATA_W bits were received.
- timeout_err  out  1  one-cycle strobe: TIMEOUT expired.
- rdy  out  1  high in IDLE.

Behaviour:
- Reset values: adc_nconv=1, data=0, data_valid=0, frame_err=0, timeout_err=0, rdy=1, state=IDLE. All synchroniser flops, the shift register and all counters are cleared.
- Synchronisation:
  - adc_busy, adc_sclk and adc_sdout each pass through a SYNC_STAGES flop chain, giving busy_s, sclk_s, sdout_s.
  - sclk_rise = sclk_s & ~sclk_s_d, where sclk_s_d is one extra register stage.
  - All three signals share the same chain depth, so sdout_s stays aligned with sclk_s.
- Protocol:
  - ADC presents bit DATA_W-1 when BUSY rises.
  - Every subsequent adc_sclk rising edge samples the current bit.
  - ADC changes data on adc_sclk falling edges.
  - BUSY falls after the last bit.
- Input constraint: adc_sclk high and low phases are each at least SYNC_STAGES+1 clk200 cycles. With a 33 MHz adc_sclk this is met at roughly 3 cycles per phase.
- FSM states:
  - IDLE: rdy=1.
    - start & ena → CONV: adc_nconv<=0, nconv_cnt<=0, tmo_cnt<=0.
    - start & ~ena → stay IDLE.
    - start in any other state is ignored; no queueing.
  - CONV:
    - nconv_cnt increments each cycle.
    - When busy_s=1 and nconv_cnt ≥ NCONV_MIN-1 → SHIFT: adc_nconv<=1, bit_cnt<=0, shreg<=0.
    - adc_nconv is released only on this transition, which prevents the ADC retriggering.
  - SHIFT:
    - On sclk_rise with bit_cnt<DATA_W: shreg<={shreg[DATA_W-2:0],sdout_s}, bit_cnt++.
    - sclk_rise with bit_cnt=DATA_W is ignored.
    - busy_s=0 with bit_cnt=DATA_W → DONE.
    - busy_s=0 with bit_cnt<DATA_W → frame_err pulse, data unchanged, → IDLE.
    - If sclk_rise and busy_s fall occur in the same cycle, the shift is applied first, then the bit count is evaluated.
  - DONE: data<=shreg, data_valid=1 for this single cycle, → IDLE. start is not accepted in DONE.
- Latency: data_valid is asserted in the cycle after busy_s is first seen low in SHIFT, i.e. SYNC_STAGES+1 clk200 cycles after the raw adc_busy falls (±1 cycle due to asynchrony).
- Timeout:
  - tmo_cnt runs in CONV and SHIFT and saturates at TIMEOUT.
  - When tmo_cnt=TIMEOUT-1: timeout_err pulse, adc_nconv<=1, → IDLE.
  - Timeout has priority over all other transitions in that cycle.
- Reset mid-frame: nrst aborts immediately to reset values, adc_nconv=1, no strobes issued.
- Back-to-back: the earliest accepted start after data_valid is the cycle after DONE (rdy=1).
- Widths:
  - bit_cnt is $clog2(DATA_W+1) bits.
  - tmo_cnt is $clog2(TIMEOUT+1) bits.
  - nconv_cnt saturates at NCONV_MIN-1.

Test Plan:
1. ADC model on a 200 MHz clock with 1 ns jitter, pattern 16'hACCF; start pulse → adc_nconv low ≥4 cycles then high on busy_s rise; data=16'hACCF with a single data_valid pulse; frame_err=timeout_err=0.
2. Ten consecutive conversions with patterns from $urandom (seed 1), start issued whenever rdy=1 → ten data_valid pulses, each data equal to the driven pattern, no error strobes.
3. ADC model drops BUSY after 9 bits → frame_err one-cycle pulse, data holds its previous value, rdy=1 the next cycle.
4. adc_busy tied 0, start → timeout_err pulse exactly TIMEOUT=1024 cycles after adc_nconv fell; adc_nconv=1 and rdy=1 afterwards.
5. start pulses during CONV, SHIFT and DONE, plus start with ena=0 in IDLE → all ignored; exactly one frame and one data_valid.
6. nrst asserted for 3 cycles during SHIFT at bit 7 → all outputs at reset values immediately; next start yields correct data 16'hACCF.
